// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// ============================================================================
// vga_timing_gen
// ----------------------------------------------------------------------------
// Free-running raster timing generator (640x480@60 Hz by default) that feeds
// pixel coordinates to the page renderers and forms the VGA output stage.
//
// Pipeline:
//   counters (h_cnt, v_cnt)
//     -> coordinate stage (1 register): screen_x/screen_y/pix_req/frame_start
//     -> renderer (external, PIPE_LAT clocks) returns pix_data_i
//   raw sync/active bits
//     -> (1+PIPE_LAT)-deep delay line -> output register: hsync/vsync/de/rgb
//
// Ports:
//   vga_clk      in   pixel clock
//   sys_rst      in   asynchronous, active-high reset
//   pix_data_i   in   RGB565 from renderer, PIPE_LAT clocks after coordinates
//   screen_x     out  active column (0 when pix_req=0)
//   screen_y     out  active row    (0 when pix_req=0)
//   pix_req      out  coordinates address a visible pixel
//   frame_start  out  one-clock pulse for counter position (0,0)
//   frame_cnt    out  completed-frame count, wraps silently
//   hsync/vsync  out  display-aligned syncs, active level SYNC_ACT
//   de           out  display-aligned data enable
//   rgb          out  registered pixel, zero outside the active window
// ============================================================================
module vga_timing_gen #(
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   H_VALID  = 640,
    parameter int   H_FRONT  = 16,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter int   V_VALID  = 480,
    parameter int   V_FRONT  = 10,
    parameter int   PIPE_LAT = 1,      // renderer latency, legal 0..7
    parameter logic SYNC_ACT = 1'b0    // active level of hsync/vsync
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [15:0] pix_data_i,
    output logic [9:0]  screen_x,
    output logic [9:0]  screen_y,
    output logic        pix_req,
    output logic        frame_start,
    output logic [7:0]  frame_cnt,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [15:0] rgb
);

    // ------------------------------------------------------------------------
    // Derived geometry. Counter widths leave room for the value H_TOTAL so the
    // active-window upper bound is representable even with a zero front porch.
    // ------------------------------------------------------------------------
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_ONE      = HW'(1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_LO   = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_ACT_HI   = HW'(H_SYNC + H_BACK + H_VALID);

    localparam logic [VW-1:0] V_ONE      = VW'(1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_LO   = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_HI   = VW'(V_SYNC + V_BACK + V_VALID);

    // Bit positions inside one delay-line stage.
    localparam int B_HS  = 0;
    localparam int B_VS  = 1;
    localparam int B_ACT = 2;

    // ------------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------------
    logic [HW-1:0] h_cnt_reg, h_cnt_next;
    logic [VW-1:0] v_cnt_reg, v_cnt_next;
    logic [7:0]    frame_cnt_reg, frame_cnt_next;
    logic          line_end;
    logic          frame_end;

    always_comb begin
        line_end       = (h_cnt_reg == H_LAST);
        frame_end      = line_end && (v_cnt_reg == V_LAST);
        h_cnt_next     = line_end ? '0 : h_cnt_reg + H_ONE;
        v_cnt_next     = v_cnt_reg;
        frame_cnt_next = frame_cnt_reg;
        if (line_end) begin
            v_cnt_next = frame_end ? '0 : v_cnt_reg + V_ONE;
        end
        if (frame_end) begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            h_cnt_reg     <= '0;
            v_cnt_reg     <= '0;
            frame_cnt_reg <= '0;
        end else begin
            h_cnt_reg     <= h_cnt_next;
            v_cnt_reg     <= v_cnt_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Raw region decode (internally active-high regardless of SYNC_ACT)
    // ------------------------------------------------------------------------
    logic raw_hs;
    logic raw_vs;
    logic h_act;
    logic v_act;
    logic raw_act;

    always_comb begin
        raw_hs  = (h_cnt_reg < H_SYNC_END);
        raw_vs  = (v_cnt_reg < V_SYNC_END);
        h_act   = (h_cnt_reg >= H_ACT_LO) && (h_cnt_reg < H_ACT_HI);
        v_act   = (v_cnt_reg >= V_ACT_LO) && (v_cnt_reg < V_ACT_HI);
        raw_act = h_act && v_act;
    end

    // ------------------------------------------------------------------------
    // Coordinate stage: one register after the counters
    // ------------------------------------------------------------------------
    logic [9:0] screen_x_reg, screen_x_next;
    logic [9:0] screen_y_reg, screen_y_next;
    logic       pix_req_reg;
    logic       frame_start_reg, frame_start_next;

    always_comb begin
        screen_x_next    = '0;
        screen_y_next    = '0;
        frame_start_next = (h_cnt_reg == '0) && (v_cnt_reg == '0);
        if (raw_act) begin
            screen_x_next = 10'(h_cnt_reg - H_ACT_LO);
            screen_y_next = 10'(v_cnt_reg - V_ACT_LO);
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            screen_x_reg    <= '0;
            screen_y_reg    <= '0;
            pix_req_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            screen_x_reg    <= screen_x_next;
            screen_y_reg    <= screen_y_next;
            pix_req_reg     <= raw_act;
            frame_start_reg <= frame_start_next;
        end
    end

    // ------------------------------------------------------------------------
    // Sync/active delay line, 1+PIPE_LAT stages. Stage 0 lines up with the
    // coordinate stage; the last stage lines up with pix_data_i, so it is the
    // qualifier for sampling the renderer output.
    // ------------------------------------------------------------------------
    logic [2:0] raw_bits;
    logic [2:0] dly_out;

    assign raw_bits = {raw_act, raw_vs, raw_hs};

    genvar gi;
    generate
        for (gi = 0; gi <= PIPE_LAT; gi++) begin : g_dly
            logic [2:0] stage_in;
            logic [2:0] stage_reg;

            if (gi == 0) begin : g_head
                assign stage_in = raw_bits;
            end else begin : g_tail
                assign stage_in = g_dly[gi-1].stage_reg;
            end

            always_ff @(posedge vga_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= stage_in;
                end
            end
        end
    endgenerate

    assign dly_out = g_dly[PIPE_LAT].stage_reg;

    // ------------------------------------------------------------------------
    // Display stage. pix_data_i is only looked at inside the delayed active
    // window, so anything the renderer drives during blanking (including X)
    // never reaches the connector.
    // ------------------------------------------------------------------------
    logic        hsync_reg, hsync_next;
    logic        vsync_reg, vsync_next;
    logic        de_reg;
    logic [15:0] rgb_reg, rgb_next;

    always_comb begin
        hsync_next = dly_out[B_HS] ? SYNC_ACT : ~SYNC_ACT;
        vsync_next = dly_out[B_VS] ? SYNC_ACT : ~SYNC_ACT;
        rgb_next   = 16'h0000;
        if (dly_out[B_ACT]) begin
            rgb_next = pix_data_i;
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hsync_reg <= ~SYNC_ACT;
            vsync_reg <= ~SYNC_ACT;
            de_reg    <= 1'b0;
            rgb_reg   <= 16'h0000;
        end else begin
            hsync_reg <= hsync_next;
            vsync_reg <= vsync_next;
            de_reg    <= dly_out[B_ACT];
            rgb_reg   <= rgb_next;
        end
    end

    // ------------------------------------------------------------------------
    // Output wiring
    // ------------------------------------------------------------------------
    assign screen_x    = screen_x_reg;
    assign screen_y    = screen_y_reg;
    assign pix_req     = pix_req_reg;
    assign frame_start = frame_start_reg;
    assign frame_cnt   = frame_cnt_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign de          = de_reg;
    assign rgb         = rgb_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen.
//   u_a      : default 640x480 geometry, PIPE_LAT=1 (reset, first pixel, mid-frame reset)
//   g_sm[n]  : small geometry (15x9 clocks) with PIPE_LAT 0/1/3, scoreboarded pass-through
//   u_w      : minimal geometry (7x5 clocks), 260 frames, frame_cnt wrap
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_s = 1'b1;
    int   cyc_a = 0;
    int   cyc_s = 0;
    int   total = 0;
    int   bad   = 0;

    // cycle k = number of rising edges since reset release
    always @(posedge clk or posedge rst_a) begin
        if (rst_a) cyc_a <= 0;
        else       cyc_a <= cyc_a + 1;
    end
    always @(posedge clk or posedge rst_s) begin
        if (rst_s) cyc_s <= 0;
        else       cyc_s <= cyc_s + 1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {
        int          cyc;
        logic [15:0] d;
    } exp_t;

    // ------------------------------------------------------------------
    // Default-geometry instance
    // ------------------------------------------------------------------
    logic [15:0] a_pix;
    logic [9:0]  a_x, a_y;
    logic        a_req, a_fs, a_hs, a_vs, a_de;
    logic [7:0]  a_fc;
    logic [15:0] a_rgb;
    assign a_pix = 16'hBEEF;

    vga_timing_gen u_a (
        .vga_clk(clk), .sys_rst(rst_a), .pix_data_i(a_pix),
        .screen_x(a_x), .screen_y(a_y), .pix_req(a_req), .frame_start(a_fs),
        .frame_cnt(a_fc), .hsync(a_hs), .vsync(a_vs), .de(a_de), .rgb(a_rgb)
    );

    task automatic check_a_reset(input string tag);
        check({tag, "_screen_x"}, a_x, 0);
        check({tag, "_screen_y"}, a_y, 0);
        check({tag, "_pix_req"}, a_req, 0);
        check({tag, "_frame_start"}, a_fs, 0);
        check({tag, "_frame_cnt"}, a_fc, 0);
        check({tag, "_de"}, a_de, 0);
        check({tag, "_rgb"}, a_rgb, 0);
        check({tag, "_hsync"}, a_hs, 1);
        check({tag, "_vsync"}, a_vs, 1);
    endtask

    task automatic scan_a(input int ncyc, output int first_hs, output int hs_len,
                          output int vs_low, output int first_req, output int req_x,
                          output int req_y, output int first_de, output int fs1,
                          output int fs2);
        bit in_run = 0;
        first_hs = -1; hs_len = 0; vs_low = 0; first_req = -1;
        req_x = -1; req_y = -1; first_de = -1; fs1 = -1; fs2 = -1;
        while (cyc_a < ncyc) begin
            @(negedge clk);
            if (a_hs == 1'b0) begin
                if (first_hs < 0) begin
                    first_hs = cyc_a; hs_len = 1; in_run = 1;
                end else if (in_run) begin
                    hs_len++;
                end
            end else begin
                in_run = 0;
            end
            if (a_vs == 1'b0) vs_low++;
            if (a_req && first_req < 0) begin
                first_req = cyc_a; req_x = a_x; req_y = a_y;
            end
            if (a_de && first_de < 0) first_de = cyc_a;
            if (cyc_a == 1) fs1 = a_fs;
            if (cyc_a == 2) fs2 = a_fs;
        end
    endtask

    // ------------------------------------------------------------------
    // Small-geometry instances: H 2,3,8,2 (15)  V 1,2,4,2 (9) -> 135/frame
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sm
            localparam int   PL = (gi == 0) ? 0 : (gi == 1) ? 1 : 3;
            localparam logic SA = (gi == 0) ? 1'b1 : 1'b0;

            logic [15:0] s_pix, rend_raw, s_rgb;
            logic [9:0]  s_x, s_y;
            logic        s_req, s_fs, s_hs, s_vs, s_de;
            logic [7:0]  s_fc;
            bit          done_f = 0;
            exp_t        q[$];

            vga_timing_gen #(
                .H_SYNC(2), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
                .V_SYNC(1), .V_BACK(2), .V_VALID(4), .V_FRONT(2),
                .PIPE_LAT(PL), .SYNC_ACT(SA)
            ) u_s (
                .vga_clk(clk), .sys_rst(rst_s), .pix_data_i(s_pix),
                .screen_x(s_x), .screen_y(s_y), .pix_req(s_req), .frame_start(s_fs),
                .frame_cnt(s_fc), .hsync(s_hs), .vsync(s_vs), .de(s_de), .rgb(s_rgb)
            );

            // Behavioural renderer: {y[5:0], x}, all-ones during blanking
            assign rend_raw = s_req ? {s_y[5:0], s_x} : 16'hFFFF;
            if (PL == 0) begin : g_r0
                assign s_pix = rend_raw;
            end else begin : g_rn
                logic [15:0] rp [PL];
                always @(posedge clk) begin
                    rp[0] <= rend_raw;
                    for (int i = 1; i < PL; i++) rp[i] <= rp[i-1];
                end
                assign s_pix = rp[PL-1];
            end

            initial begin
                exp_t e;
                int   run = 0, hs_starts = 0, vs_cnt = 0, de_cnt = 0, fs_cnt = 0, c;
                bit   hs_prev = 0, hs_act, vs_act;
                // expected display stream for 3 frames, hand-derived positions
                for (int f = 0; f < 3; f++)
                    for (int y = 0; y < 4; y++)
                        for (int x = 0; x < 8; x++) begin
                            e.cyc = f * 135 + (3 + y) * 15 + 5 + x + 2 + PL;
                            e.d   = {6'(y), 10'(x)};
                            q.push_back(e);
                        end
                while (cyc_s < 420) begin
                    @(negedge clk);
                    if (rst_s) continue;
                    c      = cyc_s;
                    hs_act = (s_hs == SA);
                    vs_act = (s_vs == SA);
                    if (s_de) begin
                        if (q.size() == 0) begin
                            check($sformatf("pl%0d_extra_de", PL), c, -1);
                        end else begin
                            e = q.pop_front();
                            $display("txn pl=%0d cyc=%0d rgb=%04h exp_cyc=%0d exp_rgb=%04h",
                                     PL, c, s_rgb, e.cyc, e.d);
                            check($sformatf("pl%0d_de_cycle", PL), c, e.cyc);
                            check($sformatf("pl%0d_rgb", PL), s_rgb, e.d);
                        end
                        run++;
                    end else begin
                        check($sformatf("pl%0d_blank_rgb", PL), s_rgb, 0);
                        if (run > 0) check($sformatf("pl%0d_line_len", PL), run, 8);
                        run = 0;
                    end
                    if (c >= 2 + PL && c < 137 + PL) begin
                        if (hs_act && !hs_prev) hs_starts++;
                        if (vs_act) vs_cnt++;
                        if (s_de) de_cnt++;
                    end
                    hs_prev = hs_act;
                    if (c >= 1 && c < 136 && s_fs) fs_cnt++;
                    if (c == 1)   check($sformatf("pl%0d_fs_cycle1", PL), s_fs, 1);
                    if (c == 134) check($sformatf("pl%0d_fcnt_pre", PL), s_fc, 0);
                    if (c == 135) check($sformatf("pl%0d_fcnt_post", PL), s_fc, 1);
                end
                check($sformatf("pl%0d_hs_pulses", PL), hs_starts, 9);
                check($sformatf("pl%0d_vs_clocks", PL), vs_cnt, 15);
                check($sformatf("pl%0d_de_clocks", PL), de_cnt, 32);
                check($sformatf("pl%0d_fs_pulses", PL), fs_cnt, 1);
                check($sformatf("pl%0d_sb_left", PL), q.size(), 0);
                done_f = 1;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Minimal geometry: H 1,1,4,1 (7)  V 1,1,2,1 (5) -> 35/frame
    // ------------------------------------------------------------------
    logic [15:0] w_pix, w_rgb;
    logic [9:0]  w_x, w_y;
    logic        w_req, w_fs, w_hs, w_vs, w_de;
    logic [7:0]  w_fc;
    bit          w_done = 0;
    assign w_pix = 16'h5A5A;

    vga_timing_gen #(
        .H_SYNC(1), .H_BACK(1), .H_VALID(4), .H_FRONT(1),
        .V_SYNC(1), .V_BACK(1), .V_VALID(2), .V_FRONT(1),
        .PIPE_LAT(1), .SYNC_ACT(1'b0)
    ) u_w (
        .vga_clk(clk), .sys_rst(rst_s), .pix_data_i(w_pix),
        .screen_x(w_x), .screen_y(w_y), .pix_req(w_req), .frame_start(w_fs),
        .frame_cnt(w_fc), .hsync(w_hs), .vsync(w_vs), .de(w_de), .rgb(w_rgb)
    );

    initial begin
        int  last_hs = -1, last_fs = -1, c;
        bit  hs_prev = 0;
        while (cyc_s < 9100) begin
            @(negedge clk);
            if (rst_s) continue;
            c = cyc_s;
            if (!w_hs && !hs_prev) begin
                if (last_hs >= 0) check("w_line_period", c - last_hs, 7);
                else              check("w_first_hs", c, 3);
                last_hs = c;
            end
            hs_prev = !w_hs;
            if (w_fs) begin
                if (last_fs >= 0) check("w_frame_period", c - last_fs, 35);
                else              check("w_first_fs", c, 1);
                last_fs = c;
            end
            if (!w_de) check("w_blank_rgb", w_rgb, 0);
            if (c == 35)   check("w_fcnt_1", w_fc, 1);
            if (c == 8959) check("w_fcnt_255", w_fc, 255);
            if (c == 8960) check("w_fcnt_wrap", w_fc, 0);
        end
        w_done = 1;
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int fh, hl, vl, fr, rx, ry, fd, f1, f2;
        int guard = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        rst_s = 1'b0;
        #1;
        check_a_reset("rst");

        scan_a(28200, fh, hl, vl, fr, rx, ry, fd, f1, f2);
        $display("txn scan1 first_hs=%0d hs_len=%0d vs_low=%0d first_req=%0d first_de=%0d",
                 fh, hl, vl, fr, fd);
        check("a_first_hs", fh, 3);
        check("a_hs_len", hl, 96);
        check("a_vs_low", vl, 1600);
        check("a_first_req", fr, 28145);
        check("a_first_x", rx, 0);
        check("a_first_y", ry, 0);
        check("a_first_de", fd, 28147);
        check("a_fs_cycle1", f1, 1);
        check("a_fs_cycle2", f2, 0);

        // mid-line reset while de/pix_req are high
        while (cyc_a < 28300) @(negedge clk);
        check("mid_de_before", a_de, 1);
        check("mid_req_before", a_req, 1);
        #2 rst_a = 1'b1;
        #1 check_a_reset("mid");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        #1 check_a_reset("rel");

        scan_a(2000, fh, hl, vl, fr, rx, ry, fd, f1, f2);
        $display("txn scan2 first_hs=%0d hs_len=%0d vs_low=%0d first_req=%0d",
                 fh, hl, vl, fr);
        check("r_first_hs", fh, 3);
        check("r_hs_len", hl, 96);
        check("r_vs_low", vl, 1600);
        check("r_no_req", fr, -1);
        check("r_fs_cycle1", f1, 1);
        check("r_fs_cycle2", f2, 0);

        while (!(g_sm[0].done_f && g_sm[1].done_f && g_sm[2].done_f && w_done)
               && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) check("monitors_timeout", guard, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
